// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage constants and state encoding
package if_stage_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    typedef enum logic {RUN, INVAL} state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: icache and IF/ID handshake bundle
// master = fetch stage; slave = icache plus decode/execute side.
// icache_*: fetch address, request, invalidate pulse, returned instruction, ready strobe
// stall/redirect/fence_i: control from later stages; id_*: IF/ID register contents
interface if_stage_if;
    logic [31:0] icache_pc_o;
    logic        icache_fetch_en_o;
    logic        icache_invalidate_o;
    logic [31:0] icache_inst_i;
    logic        icache_ready_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fence_i_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    modport master (
        output icache_pc_o, icache_fetch_en_o, icache_invalidate_o, id_valid_o, id_inst_o, id_pc_o,
        input  icache_inst_i, icache_ready_i, stall_i, redirect_i, redirect_pc_i, fence_i_i
    );
    modport slave (
        input  icache_pc_o, icache_fetch_en_o, icache_invalidate_o, id_valid_o, id_inst_o, id_pc_o,
        output icache_inst_i, icache_ready_i, stall_i, redirect_i, redirect_pc_i, fence_i_i
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with IF/ID register, pending redirects and FENCE.I invalidate
// clk, rst_n (async, active-low); bus: if_stage_if.master
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input logic       clk,
    input logic       rst_n,
    if_stage_if.master bus
);
    state_t      state_q;
    logic        fetch_en_q;
    logic        pend_v_q;
    logic        pend_fence_q;
    logic [31:0] pend_pc_q;
    logic [31:0] pc_q;
    logic        id_valid_q;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc_q;
    logic        redir;
    logic        fence;
    logic        hit;
    logic        accept;
    logic [31:0] tgt;
    // A live redirect_i always wins over a parked one.
    assign redir  = bus.redirect_i | pend_v_q;
    assign tgt    = bus.redirect_i ? (bus.redirect_pc_i & ~32'd3) : pend_pc_q;
    assign fence  = bus.fence_i_i | pend_fence_q;
    // fetch_en_q is low in the first cycle after reset, so a ready there is not a real hit.
    assign hit    = (state_q == RUN) && fetch_en_q && bus.icache_ready_i;
    assign accept = hit && !redir && (!id_valid_q || !bus.stall_i);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            fetch_en_q   <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_fence_q <= 1'b0;
            pend_pc_q    <= '0;
            pc_q         <= RESET_PC & ~32'd3;
            id_valid_q   <= 1'b0;
            id_inst_q    <= NOP_INST;
            id_pc_q      <= '0;
        end else begin
            state_q    <= (hit && redir && fence) ? INVAL : RUN;
            fetch_en_q <= !(hit && redir && fence);
            if (hit && redir) begin
                pc_q         <= tgt;
                pend_v_q     <= 1'b0;
                pend_fence_q <= 1'b0;
            end else if (accept) begin
                pc_q <= pc_q + 32'd4;
            end else if (bus.redirect_i) begin
                pend_v_q     <= 1'b1;
                pend_pc_q    <= tgt;
                pend_fence_q <= pend_fence_q | bus.fence_i_i;
            end
            if (accept) begin
                id_valid_q <= 1'b1;
                id_inst_q  <= bus.icache_inst_i;
                id_pc_q    <= pc_q;
            end else if (redir || !bus.stall_i) begin
                id_valid_q <= 1'b0;
            end
        end
    end
    assign bus.icache_pc_o         = pc_q;
    assign bus.icache_fetch_en_o   = fetch_en_q;
    assign bus.icache_invalidate_o = (state_q == INVAL);
    assign bus.id_valid_o          = id_valid_q;
    assign bus.id_inst_o           = id_inst_q;
    assign bus.id_pc_o             = id_pc_q;
endmodule
